i2c_target_regs: RTL and testbench

I2C target (responder) mapping an 8-bit register space onto an I2C bus. It is the far end of the open-drain I2C initiators already in the system. Used for board-level loopback tests and as the management slave behind the QSFP/oscillator I2C pins. It exposes the same sda_in/scl_in/sda_oe/scl_oe pin convention, plus a simple single-cycle register port toward local logic.

---
 rtl/i2c_target_pkg.sv | 20 ++
 rtl/i2c_line_filter.sv | 52 +++++
 rtl/i2c_target_regs.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

  localparam int BYTE_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one raw I2C pin and suppresses glitches shorter than
// FILTER_CYCLES clocks; reports the filtered level and its edges.
module i2c_line_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer; idles high like a released bus line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], line_in};
    end
  end

  // Filtered level follows the synchronized line only after it has differed
  // for FILTER_CYCLES consecutive samples; edge pulses coincide with the change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register space through a single-cycle
// local register port. No clock stretching; every written byte is ACKed.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h50,
  parameter int         FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] pointer;
  logic       rw;
  logic       first_byte;
  logic       phase;
  logic       rd_pend;

  logic       start_cond;
  logic       stop_cond;
  logic       last_bit;
  logic [7:0] rx_byte;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (scl_in),
    .level   (scl_f),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (sda_in),
    .level   (sda_f),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign scl_oe     = 1'b0;
  assign reg_addr   = pointer;
  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;
  assign last_bit   = (bit_cnt == 4'(BYTE_W - 1));
  assign rx_byte    = {shift[6:0], sda_f};

  // Bus protocol engine: START/STOP override everything, otherwise each state
  // reacts to filtered SCL edges. Strobes are one clk; the pointer advances and
  // read data lands in the shift register in the clocks after each strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      pointer    <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      phase      <= 1'b0;
      rd_pend    <= 1'b0;
      sda_oe     <= 1'b0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      rd_pend <= reg_rd;
      if (rd_pend) shift <= reg_rdata;
      if (reg_wr || reg_rd) pointer <= pointer + 8'd1;

      if (start_cond) begin
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        busy    <= 1'b0;
        state   <= ADDR;
      end else if (stop_cond) begin
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        state  <= IDLE;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy  <= 1'b1;
                  rw    <= rx_byte[0];
                  phase <= 1'b0;
                  state <= ADDR_ACK;
                  if (rx_byte[0]) reg_rd <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end

          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= ~ACK;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  sda_oe <= ~shift[7];
                  state  <= RD_DATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WR_DATA;
                  if (state == ADDR_ACK) first_byte <= 1'b1;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                phase   <= 1'b0;
                state   <= WR_ACK;
                if (first_byte) begin
                  pointer    <= rx_byte;
                  first_byte <= 1'b0;
                end else begin
                  reg_wr    <= 1'b1;
                  reg_wdata <= rx_byte;
                end
              end
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'(BYTE_W)) begin
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shift[7];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_f == NACK) begin
                busy  <= 1'b0;
                state <= IGNORE;
              end else begin
                reg_rd <= 1'b1;
                phase  <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              sda_oe  <= ~shift[7];
              state   <= RD_DATA;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C initiator, local register memory,
// and a byte-level transaction model feeding expected register strobes.
module tb_i2c_target_regs;

  localparam logic [6:0] DEV = 7'h50;
  localparam int FC = 4;
  localparam int Q  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        scl_line;
  wire        sda_line;
  logic       scl_oe, sda_oe, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  model_mem [256];
  logic [7:0]  dev_mem   [256];
  logic [7:0]  model_ptr;
  logic        model_first, model_busy, model_match;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  exp_data_q [$];
  logic        expect_silent = 1'b0;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  always #4 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(DEV), .FILTER_CYCLES(FC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_line),
    .sda_in    (sda_line),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic scl_v, input logic sda_v, input int n);
    scl_m = scl_v;
    sda_m = sda_v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Local register memory: writes land immediately, read data one clk after reg_rd.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && reg_wr) dev_mem[reg_addr] = reg_wdata;
      if (reset_n && reg_rd) begin
        automatic logic [7:0] a = reg_addr;
        @(posedge clk);
        #1 reg_rdata = dev_mem[a];
      end
    end
  end

  // Per-cycle comparison of register strobes and pin enables against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        checkOutput("scl_oe_tied", scl_oe, 0);
        checkOutput("wr_rd_exclusive", reg_wr & reg_rd, 0);
        if (expect_silent) checkOutput("sda_oe_silent", sda_oe, 0);
        if (reg_wr) begin
          if (exp_wr_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_reg_wr: got addr 0x%0h data 0x%0h, required no write", reg_addr, reg_wdata);
          end else begin
            checkOutput("reg_wr_addr_data", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
          end
        end
        if (reg_rd) begin
          if (exp_rd_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_reg_rd: got addr 0x%0h, required no read", reg_addr);
          end else begin
            checkOutput("reg_rd_addr", reg_addr, exp_rd_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- transaction model ----------------
  task automatic resetModel();
    model_ptr   = 8'h00;
    model_busy  = 1'b0;
    model_first = 1'b0;
    model_match = 1'b0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_data_q.delete();
  endtask

  task automatic modelRead();
    exp_rd_q.push_back(model_ptr);
    exp_data_q.push_back(model_mem[model_ptr]);
    model_ptr = model_ptr + 8'd1;
  endtask

  task automatic modelAddr(input logic [7:0] b);
    model_match = (b[7:1] == DEV);
    model_first = 1'b1;
    if (model_match) begin
      model_busy = 1'b1;
      if (b[0]) modelRead();
    end
  endtask

  task automatic modelWriteData(input logic [7:0] b);
    if (model_match) begin
      if (model_first) begin
        model_ptr   = b;
        model_first = 1'b0;
      end else begin
        exp_wr_q.push_back({model_ptr, b});
        model_mem[model_ptr] = b;
        model_ptr = model_ptr + 8'd1;
      end
    end
  endtask

  // ---------------- bus primitives ----------------
  task automatic sendBit(input logic b, output logic s);
    applyStimulus(1'b0, b, Q);
    applyStimulus(1'b1, b, Q);
    s = sda_line;
    applyStimulus(1'b1, b, Q);
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic startCond();
    applyStimulus(scl_m, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic stopCond();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) sendBit(b[i], s);
    sendBit(1'b1, ack);
  endtask

  task automatic readByte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sendBit(1'b1, s);
      d[i] = s;
    end
    sendBit(mack, s);
  endtask

  // ---------------- transaction helpers ----------------
  task automatic doStart();
    model_busy = 1'b0;
    startCond();
  endtask

  task automatic doStop();
    model_busy = 1'b0;
    stopCond();
    checkOutput("busy_after_stop", busy, 0);
  endtask

  task automatic sendAddr(input logic [7:0] b);
    logic ack;
    modelAddr(b);
    writeByte(b, ack);
    checkOutput("addr_ack", ack, model_match ? 16'd0 : 16'd1);
    checkOutput("busy_after_addr", busy, model_busy);
  endtask

  task automatic sendData(input logic [7:0] b);
    logic ack;
    modelWriteData(b);
    writeByte(b, ack);
    checkOutput("data_ack", ack, model_match ? 16'd0 : 16'd1);
    checkOutput("busy_after_data", busy, model_busy);
  endtask

  task automatic recvData(input logic mack, output logic [7:0] d);
    logic [7:0] exp_d;
    if (mack == 1'b0) modelRead();
    else model_busy = 1'b0;
    readByte(mack, d);
    if (exp_data_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL read_model_empty: got 0x%0h, required a modelled byte", d);
    end else begin
      exp_d = exp_data_q.pop_front();
      checkOutput("read_data", d, exp_d);
    end
    checkOutput("busy_after_read", busy, model_busy);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0] d0, d1;
    logic       s, ack;

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      dev_mem[i]   = 8'h00;
    end
    model_mem[8'h20] = 8'h3C; dev_mem[8'h20] = 8'h3C;
    model_mem[8'h21] = 8'hC3; dev_mem[8'h21] = 8'hC3;
    resetModel();

    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("reset_sda_oe", sda_oe, 0);
    checkOutput("reset_scl_oe", scl_oe, 0);
    checkOutput("reset_strobes", {reg_wr, reg_rd}, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_reg_addr", reg_addr, 8'h00);
    checkOutput("reset_reg_wdata", reg_wdata, 8'h00);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 20);

    $display("[TB] write burst with pointer byte");
    doStart();
    sendAddr(8'hA0);
    sendData(8'h10);
    sendData(8'hA5);
    sendData(8'h5A);
    checkOutput("t1_busy_before_stop", busy, 1);
    doStop();
    checkOutput("t1_model_ptr", model_ptr, 8'h12);
    checkOutput("t1_mem10", dev_mem[8'h10], 8'hA5);
    checkOutput("t1_mem11", dev_mem[8'h11], 8'h5A);

    $display("[TB] pointer write, repeated start, two-byte read");
    doStart();
    sendAddr(8'hA0);
    sendData(8'h20);
    doStart();
    sendAddr(8'hA1);
    recvData(1'b0, d0);
    recvData(1'b1, d1);
    checkOutput("t2_byte0", d0, 8'h3C);
    checkOutput("t2_byte1", d1, 8'hC3);
    checkOutput("t2_busy_after_nack", busy, 0);
    doStop();

    $display("[TB] foreign address is ignored");
    expect_silent = 1'b1;
    doStart();
    sendAddr(8'hA2);
    sendData(8'h11);
    sendData(8'h22);
    sendData(8'h33);
    doStop();
    expect_silent = 1'b0;

    $display("[TB] pointer wrap");
    doStart();
    sendAddr(8'hA0);
    sendData(8'hFF);
    sendData(8'hDE);
    sendData(8'hAD);
    doStop();
    checkOutput("t4_model_ptr", model_ptr, 8'h01);
    checkOutput("t4_memFF", dev_mem[8'hFF], 8'hDE);
    checkOutput("t4_mem00", dev_mem[8'h00], 8'hAD);

    $display("[TB] SDA glitches while SCL high");
    doStart();
    sendAddr(8'hA0);
    sendData(8'h30);
    modelWriteData(8'h42);
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, FC - 1);
    applyStimulus(1'b1, 1'b0, Q);
    checkOutput("t5_busy_short_glitch", busy, 1);
    applyStimulus(1'b0, 1'b0, Q);
    for (int i = 6; i >= 0; i--) sendBit(1'(8'h42 >> i), s);
    sendBit(1'b1, ack);
    checkOutput("t5_ack_after_glitch", ack, 0);
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, FC + 1);
    applyStimulus(1'b1, 1'b0, Q);
    model_busy = 1'b0;
    checkOutput("t5_busy_long_glitch", busy, 0);
    applyStimulus(1'b0, 1'b0, Q);
    stopCond();
    checkOutput("t5_mem30", dev_mem[8'h30], 8'h42);

    $display("[TB] STOP mid-byte, then a full write");
    doStart();
    sendAddr(8'hA0);
    sendData(8'h50);
    sendBit(1'b1, s);
    sendBit(1'b0, s);
    sendBit(1'b1, s);
    sendBit(1'b1, s);
    doStop();
    doStart();
    sendAddr(8'hA0);
    sendData(8'h60);
    sendData(8'h11);
    doStop();
    checkOutput("t6_mem60", dev_mem[8'h60], 8'h11);

    $display("[TB] reset during read while driving low");
    doStart();
    sendAddr(8'hA0);
    sendData(8'h20);
    doStart();
    sendAddr(8'hA1);
    checkOutput("t7_drive_msb", sda_oe, 1);
    sendBit(1'b1, s);
    checkOutput("t7_first_read_bit", s, 0);
    checkOutput("t7_drive_bit6", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("t7_sda_oe_async", sda_oe, 0);
    checkOutput("t7_busy_async", busy, 0);
    checkOutput("t7_reg_addr_async", reg_addr, 8'h00);
    resetModel();
    applyStimulus(1'b1, 1'b1, Q);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, Q);
    doStart();
    sendAddr(8'hA0);
    sendData(8'h70);
    sendData(8'h77);
    doStop();
    checkOutput("t7_mem70", dev_mem[8'h70], 8'h77);

    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("pending_writes", 16'(exp_wr_q.size()), 0);
    checkOutput("pending_reads", 16'(exp_rd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
